// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer.
// Provides the default geometry (depth, address/data widths), the derived
// pointer/count widths, and the entry record {addr, data}.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Memory-side bus of the store buffer.
//   mem_raddr  : load address, passed straight through from the core
//   mem_rdata  : load data from memory, same cycle
//   mem_we     : drain request (valid), head entry present
//   mem_waddr  : head entry address
//   mem_wdata  : head entry data
//   mem_wready : memory accepts the write (ready)
// Handshake: a write transfers on a rising edge where mem_we and mem_wready
// are both 1. While mem_we=1 and mem_wready=0, mem_waddr/mem_wdata hold
// steady. mem_wready is ignored when mem_we=0.
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) ();

  logic          mem_we;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  // master: the store buffer
  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_raddr,
    input  mem_wready, mem_rdata
  );

  // slave: the data memory
  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_raddr,
    output mem_wready, mem_rdata
  );

endinterface

// File: rtl/sb_match.sv
// Youngest-first address match over the store buffer entries.
//   valid     : per-slot valid bits
//   word_addr : per-slot word address (byte address without [1:0])
//   head      : slot of the oldest entry
//   lookup    : word address being searched
//   hit       : some valid entry matches
//   idx       : slot of the youngest matching entry (head when no hit)
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WA    = SB_AW - 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][WA-1:0] word_addr,
  input  logic [PW-1:0]            head,
  input  logic [WA-1:0]            lookup,
  output logic                     hit,
  output logic [PW-1:0]            idx
);

  logic [PW-1:0] slot;

  // Valid entries are contiguous from head, so scanning oldest to youngest
  // and letting later matches overwrite earlier ones leaves the youngest.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (valid[slot] && (word_addr[slot] == lookup)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between the core memory stage and data memory.
// Stores are queued in order and drained through a valid/ready write port;
// loads forward from the youngest matching queued store, else from memory.
//   clk, reset          : clock, asynchronous active-high reset
//   memwrite, memread   : core store / load request
//   dataadr, writedata  : core byte address and store data
//   readdata            : load data to core (combinational)
//   stall               : core must hold its store (combinational)
//   sb_empty, sb_count  : occupancy status
//   mem                 : memory bus (store_buffer_if.master)
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic                       memread,
  input  logic [AW-1:0]              dataadr,
  input  logic [DW-1:0]              writedata,
  output logic [DW-1:0]              readdata,
  output logic                       stall,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH+1)-1:0] sb_count,
  store_buffer_if.master             mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WA = AW - 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]  addr_q [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;

  logic [PW-1:0]  youngest;
  logic           merge, push, drain;
  logic [DEPTH-1:0][WA-1:0] word_addr;
  logic           hit;
  logic [PW-1:0]  hit_idx;

  assign youngest = tail_q - PW'(1);

  // The head is never a merge target (count >= 2 keeps tail-1 != head),
  // so data already presented to memory never changes under it.
  assign merge = memwrite && (count_q >= CW'(2)) &&
                 (addr_q[youngest][AW-1:2] == dataadr[AW-1:2]);
  assign push  = memwrite && !merge && (count_q != FULL);
  // Stall looks only at the current count; a slot freed by a drain this
  // cycle becomes usable on the next cycle.
  assign stall = memwrite && !merge && (count_q == FULL);
  assign drain = (count_q != '0) && mem.mem_wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // push writes tail, drain frees head; they are distinct slots
      // whenever both can happen (1 <= count < DEPTH).
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= dataadr;
      data_q[tail_q] <= writedata;
    end else if (merge) begin
      data_q[youngest] <= writedata;
    end
  end

  always_comb begin
    word_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word_addr[i] = addr_q[i][AW-1:2];
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .WA    (WA)
  ) u_match (
    .valid     (valid_q),
    .word_addr (word_addr),
    .head      (head_q),
    .lookup    (dataadr[AW-1:2]),
    .hit       (hit),
    .idx       (hit_idx)
  );

  assign readdata = (memread && hit) ? data_q[hit_idx] : mem.mem_rdata;

  assign mem.mem_raddr = dataadr;
  assign mem.mem_we    = (count_q != '0);
  assign mem.mem_waddr = addr_q[head_q];
  assign mem.mem_wdata = data_q[head_q];

  assign sb_empty = (count_q == '0);
  assign sb_count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, ordered drain, full/stall,
// merge, forwarding and push+drain at count 1.
module tb_store_buffer;
  import sb_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic        sb_empty;
  logic [2:0]  sb_count;

  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32)) mem_if ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .sb_empty  (sb_empty),
    .sb_count  (sb_count),
    .mem       (mem_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int got_rd   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the values seen at the
  // falling edge are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!reset && mem_if.mem_we && mem_if.mem_wready) begin
      got_q.push_back({mem_if.mem_waddr, mem_if.mem_wdata});
      got_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (mem_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_if.mem_we); end
    n_checks++;
    if (sb_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sb_count); end
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int w0;
    mem_if.mem_wready = 1'b0;
    store(32'd16, 32'd1);
    store(32'd20, 32'd2);
    store(32'd24, 32'd3);
    n_checks++;
    if (sb_count !== 3'd3) begin n_fail++; $display("FAIL rmd_fill_count: got %0d want 3", sb_count); end
    n_checks++;
    if (mem_if.mem_we !== 1'b1) begin n_fail++; $display("FAIL rmd_fill_we: got %b want 1", mem_if.mem_we); end
    reset = 1'b1;
    #2;
    n_checks++;
    if (mem_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmd_we: got %b want 0", mem_if.mem_we); end
    n_checks++;
    if (sb_count !== 3'd0) begin n_fail++; $display("FAIL rmd_count: got %0d want 0", sb_count); end
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL rmd_empty: got %b want 1", sb_empty); end
    tick();
    reset = 1'b0;
    w0 = got_q.size();
    mem_if.mem_wready = 1'b1;
    mem_if.mem_rdata  = 32'h0000_1234;
    memread = 1'b1;
    dataadr = 32'd16;
    #2;
    n_checks++;
    if (readdata !== 32'h0000_1234) begin n_fail++; $display("FAIL rmd_no_forward: got %h want 00001234", readdata); end
    idle(3);
    memread = 1'b0;
    n_checks++;
    if (got_q.size() !== w0) begin n_fail++; $display("FAIL rmd_no_writes: got %0d writes want 0", got_q.size() - w0); end
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  task automatic test_ordered_drain();
    logic [63:0] e;
    mem_if.mem_wready = 1'b1;
    exp_q.push_back({32'd84, 32'd7});
    exp_q.push_back({32'd80, 32'd5});
    store(32'd84, 32'd7);
    store(32'd80, 32'd5);
    idle(2);
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL od_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (got_q.size() !== got_rd + exp_q.size()) begin n_fail++; $display("FAIL od_write_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    n_checks++;
    if (got_q.size() >= got_rd + 2 && got_cyc[got_rd+1] - got_cyc[got_rd] !== 1) begin n_fail++; $display("FAIL od_consecutive: got gap %0d want 1", got_cyc[got_rd+1] - got_cyc[got_rd]); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL od_write: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  task automatic test_full_stall();
    logic [63:0] e;
    mem_if.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'(8'hA0 + i));
    n_checks++;
    if (sb_count !== 3'd4) begin n_fail++; $display("FAIL fs_full_count: got %0d want 4", sb_count); end
    memwrite = 1'b1; dataadr = 32'd16; writedata = 32'hA4;
    #2;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL fs_stall: got %b want 1", stall); end
    tick();
    n_checks++;
    if (sb_count !== 3'd4) begin n_fail++; $display("FAIL fs_hold_count: got %0d want 4", sb_count); end
    exp_q.push_back({32'd0, 32'hA0});
    mem_if.mem_wready = 1'b1;
    #2;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL fs_stall_drain: got %b want 1", stall); end
    tick();
    mem_if.mem_wready = 1'b0;
    #2;
    n_checks++;
    if (sb_count !== 3'd3 || stall !== 1'b0) begin n_fail++; $display("FAIL fs_freed: got count=%0d stall=%b want count=3 stall=0", sb_count, stall); end
    tick();
    memwrite = 1'b0;
    n_checks++;
    if (sb_count !== 3'd4) begin n_fail++; $display("FAIL fs_accept_count: got %0d want 4", sb_count); end
    for (int i = 1; i < 5; i++) exp_q.push_back({32'(4 * i), 32'(8'hA0 + i)});
    mem_if.mem_wready = 1'b1;
    idle(5);
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL fs_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (got_q.size() !== got_rd + exp_q.size()) begin n_fail++; $display("FAIL fs_write_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL fs_write: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  task automatic test_merge();
    logic [63:0] e;
    mem_if.mem_wready = 1'b0;
    store(32'd100, 32'd1);
    store(32'd104, 32'd2);
    store(32'd104, 32'd9);
    n_checks++;
    if (sb_count !== 3'd2) begin n_fail++; $display("FAIL mg_count: got %0d want 2", sb_count); end
    n_checks++;
    if (mem_if.mem_waddr !== 32'd100 || mem_if.mem_wdata !== 32'd1) begin n_fail++; $display("FAIL mg_head: got %0d/%0d want 100/1", mem_if.mem_waddr, mem_if.mem_wdata); end
    exp_q.push_back({32'd100, 32'd1});
    exp_q.push_back({32'd104, 32'd9});
    mem_if.mem_wready = 1'b1;
    idle(3);
    mem_if.mem_wready = 1'b0;
    store(32'd100, 32'd3);
    store(32'd100, 32'd4);
    n_checks++;
    if (sb_count !== 3'd2) begin n_fail++; $display("FAIL mg_no_merge_count1: got %0d want 2", sb_count); end
    exp_q.push_back({32'd100, 32'd3});
    exp_q.push_back({32'd100, 32'd4});
    mem_if.mem_wready = 1'b1;
    idle(3);
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL mg_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (got_q.size() !== got_rd + exp_q.size()) begin n_fail++; $display("FAIL mg_write_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL mg_write: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  task automatic test_forward();
    logic [63:0] e;
    logic [31:0] la[4];
    logic [31:0] ld[4];
    la = '{32'd84, 32'd86, 32'd88, 32'd92};
    ld = '{32'd11, 32'd11, 32'd1, 32'hDEAD_BEEF};
    mem_if.mem_wready = 1'b0;
    mem_if.mem_rdata  = 32'hDEAD_BEEF;
    store(32'd84, 32'd7);
    store(32'd88, 32'd1);
    store(32'd84, 32'd11);
    n_checks++;
    if (sb_count !== 3'd3) begin n_fail++; $display("FAIL fw_count: got %0d want 3", sb_count); end
    for (int i = 0; i < 4; i++) begin
      memread = 1'b1;
      dataadr = la[i];
      #2;
      n_checks++;
      if (readdata !== ld[i]) begin n_fail++; $display("FAIL fw_load addr=%0d: got %h want %h", la[i], readdata, ld[i]); end
      tick();
    end
    exp_q.push_back({32'd84, 32'd7});
    exp_q.push_back({32'd88, 32'd1});
    exp_q.push_back({32'd84, 32'd11});
    mem_if.mem_wready = 1'b1;
    tick();
    dataadr = 32'd88;
    #2;
    n_checks++;
    if (readdata !== 32'd1) begin n_fail++; $display("FAIL fw_draining_entry: got %h want 1", readdata); end
    tick();
    memread = 1'b0;
    idle(2);
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL fw_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (got_q.size() !== got_rd + exp_q.size()) begin n_fail++; $display("FAIL fw_write_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL fw_write: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  task automatic test_push_drain();
    logic [63:0] e;
    mem_if.mem_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({32'(200 + 4 * i), 32'(8'h50 + i)});
      memwrite  = 1'b1;
      dataadr   = 32'(200 + 4 * i);
      writedata = 32'(8'h50 + i);
      #2;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL pd_stall[%0d]: got %b want 0", i, stall); end
      tick();
      n_checks++;
      if (sb_count !== 3'd1) begin n_fail++; $display("FAIL pd_count[%0d]: got %0d want 1", i, sb_count); end
    end
    memwrite = 1'b0;
    idle(2);
    n_checks++;
    if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL pd_empty: got %b want 1", sb_empty); end
    n_checks++;
    if (got_q.size() !== got_rd + exp_q.size()) begin n_fail++; $display("FAIL pd_write_count: got %0d want %0d", got_q.size() - got_rd, exp_q.size()); end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[got_rd] !== e) begin n_fail++; $display("FAIL pd_write: got %h want %h", got_q[got_rd], e); end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
    mem_if.mem_wready = 1'b0;
  endtask

  initial begin
    mem_if.mem_wready = 1'b0;
    mem_if.mem_rdata  = '0;
    test_reset();
    test_reset_mid_drain();
    test_ordered_drain();
    test_full_stall();
    test_merge();
    test_forward();
    test_push_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
